sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
// - Single-clock controller sequencing the fifomem dual-port RAM as a synchronous FIFO.
// - Owns write/read pointers, drives the memory's waddr/raddr/wclken/wfull, and produces full/empty/almost/count status.
// - Sits beside fifomem in the FIFO_Design tree; the same-clock counterpart of the async pointer/flag logic.
// PARAMETERS
// - DATASIZE  8   memory word width; no data passes through this block, used only for the package/typedefs
// - ADDRSIZE  4   memory address bits; DEPTH = 1<<ADDRSIZE
// - AF_LEVEL  DEPTH-2   almost_full asserts when count >= AF_LEVEL
// - AE_LEVEL  2         almost_empty asserts when count <= AE_LEVEL
// PORTS
// - clk           in   1           single clock; the memory's wclk is tied to it
// - rst           in   1           synchronous, active-high reset
// - wr_en         in   1           push request
// - rd_en         in   1           pop request; data is on fifomem rdata in the same cycle
// - waddr         out  ADDRSIZE    to fifomem waddr
// - raddr         out  ADDRSIZE    to fifomem raddr
// - wclken        out  1           to fifomem wclken; = wr_en & ~full
// - wfull         out  1           to fifomem wfull; = full
// - full          out  1           FIFO holds DEPTH words
// - empty         out  1           FIFO holds 0 words
// - almost_full   out  1           count >= AF_LEVEL
// - almost_empty  out  1           count <= AE_LEVEL
// - count         out  ADDRSIZE+1  occupancy, 0..DEPTH
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
// - Pointers: wptr and rptr are ADDRSIZE+1 bits (MSB = wrap bit). waddr = wptr[ADDRSIZE-1:0]; raddr = rptr[ADDRSIZE-1:0].
// - Reset values: on rst at a clk edge, wptr = rptr = 0.
//   The outputs are then empty = 1, almost_empty = 1 (AE_LEVEL >= 0), full = 0, almost_full = 0, count = 0, wclken = 0.
// - rst takes priority over wr_en/rd_en.
// - Mid-operation reset discards all contents; memory contents are not cleared.
// - Write acceptance: wr_acc = wr_en & ~full.
//   - wptr increments at the edge.
//   - fifomem stores wdata at waddr on the same edge.
// - Read acceptance: rd_acc = rd_en & ~empty.
//   - rdata (async read at raddr) is valid during the rd_en cycle.
//   - rptr increments at the edge.
// - Flags:
//   - full = (wptr[MSB] != rptr[MSB]) & (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]).
//   - empty = (wptr == rptr).
//   - All flags are decoded from registered pointers only. There is no combinational path from wr_en/rd_en to any flag.
// - count = wptr - rptr, modulo 2^(ADDRSIZE+1).
// - Latency:
//   - A word written at edge N is readable in the cycle after edge N (empty deasserts then).
//   - A freed slot after a pop at edge N is writable in the cycle after edge N.
// - Simultaneous events:
//   - wr+rd when not full and not empty: both accepted, count unchanged.
//   - wr+rd when full: read accepted, write rejected; count -> DEPTH-1.
//   - wr+rd when empty: write accepted, read rejected (no fall-through); count -> 1.
// - Wrap: pointers roll from 2^(ADDRSIZE+1)-1 to 0. The MSB toggles each lap, so full and empty stay unambiguous.
// - A rejected request has no side effect other than the optional error flags.
// CONFIGURATION
// - Macro FIFO_ERR_FLAGS_EN.
//   - When defined, adds outputs overflow and underflow (1 bit each, reset 0).
//     - overflow sets sticky on wr_en & full; underflow sets sticky on rd_en & empty.
//     - Both clear only on rst.
//   - When undefined, these ports and their registers do not exist; rejected requests are silently dropped.
// STRUCTURE
// - Package fifo_pkg:
//   - typedefs addr_t [ADDRSIZE-1:0], ptr_t [ADDRSIZE:0], data_t [DATASIZE-1:0].
//   - localparam DEPTH.
// - Sub-module fifo_ptr: one instance each for wptr and rptr.
//   - A (ADDRSIZE+1)-bit incrementing pointer with sync reset and an enable.
// - fifomem is instantiated by the parent wrapper, not by this block.
// TESTING
// - Reset then idle -> empty = 1, full = 0, count = 0, waddr = raddr = 0, wclken = 0.
// - 16 writes of 0x00..0x0F (ADDRSIZE = 4), then a 17th write.
//   - After the 16th: full = 1, count = 16, almost_full = 1.
//   - On the 17th: wclken = 0, wptr unchanged, overflow = 1 if FIFO_ERR_FLAGS_EN.
// - Fill to 16, then wr_en + rd_en together for 1 cycle -> rdata = 0x00 popped, count = 15, full = 0, no write.
// - From empty, wr_en + rd_en together -> count = 1, empty = 0 next cycle.
//   - rd_en alone when empty -> rptr unchanged, underflow = 1 if FIFO_ERR_FLAGS_EN.
// - 40 interleaved push/pop of an incrementing pattern -> both pointers wrap past 31 -> 0.
//   - Data is read in order; count never exceeds 16 and never underflows.
// - Write 5 words, assert rst for 1 cycle mid-burst -> empty = 1 and count = 0 next cycle; the next write lands at waddr 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizes and typedefs for the synchronous FIFO controller.
package fifo_pkg;
  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;
  localparam int DEPTH = 1 << ADDRSIZE;
  typedef logic [ADDRSIZE-1:0] addr_t;
  typedef logic [ADDRSIZE:0] ptr_t;
  typedef logic [DATASIZE-1:0] data_t;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer that increments on enable, sync active-high reset.
module fifo_ptr #(
  parameter int W = fifo_pkg::ADDRSIZE + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = en_i ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock pointer/flag controller for fifomem.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                wclken,
  output logic                wfull,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);
  localparam logic [31:0] AF32 = AF_LEVEL;
  localparam logic [31:0] AE32 = AE_LEVEL;
  localparam logic [ADDRSIZE:0] AF = AF32[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AE = AE32[ADDRSIZE:0];
  logic [ADDRSIZE:0] wptr, rptr;
  logic wr_acc, rd_acc;
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  fifo_ptr #(.W(ADDRSIZE + 1)) u_wptr (.clk(clk), .rst(rst), .en_i(wr_acc), .ptr_o(wptr));
  fifo_ptr #(.W(ADDRSIZE + 1)) u_rptr (.clk(clk), .rst(rst), .en_i(rd_acc), .ptr_o(rptr));
  // Flags decode registered pointers only; the MSB distinguishes full from empty.
  always_comb begin
    waddr = wptr[ADDRSIZE-1:0];
    raddr = rptr[ADDRSIZE-1:0];
    full = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) && (waddr == raddr);
    empty = wptr == rptr;
    count = wptr - rptr;
    almost_full = count >= AF;
    almost_empty = count <= AE;
    wfull = full;
    wclken = wr_acc;
  end
`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  always_comb begin
    ovf_d = ovf_q | (wr_en & full);
    unf_d = unf_q | (rd_en & empty);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign overflow = ovf_q;
  assign underflow = unf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench with a queue-based FIFO reference and a local fifomem stand-in.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [3:0] waddr, raddr;
  logic wclken, wfull, full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  sync_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .waddr(waddr), .raddr(raddr), .wclken(wclken), .wfull(wfull),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] mem [16];
  always @(posedge clk) if (wclken) mem[waddr] <= wdata;
  logic [7:0] q_m[$];
  logic [7:0] exp_q[$];
  int wtot = 0, rtot = 0;
  bit ovf_m = 0, unf_m = 0, known = 0;
  bit e_valid = 0, e_wclken, e_full, e_empty, e_af, e_ae, e_ovf, e_unf;
  int e_count, e_waddr, e_raddr;
  int passed = 0, total = 0;
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
  endtask
  task automatic step(input bit w, input bit r, input bit rs, input logic [7:0] d);
    int sz;
    @(posedge clk);
    #1;
    wr_en = w;
    rd_en = r;
    rst = rs;
    wdata = d;
    sz = q_m.size();
    e_valid = known;
    e_count = sz;
    e_full = sz == 16;
    e_empty = sz == 0;
    e_af = sz >= 14;
    e_ae = sz <= 2;
    e_waddr = wtot % 16;
    e_raddr = rtot % 16;
    e_wclken = w && sz != 16;
    e_ovf = ovf_m;
    e_unf = unf_m;
    if (rs) begin
      q_m.delete();
      wtot = 0;
      rtot = 0;
      ovf_m = 0;
      unf_m = 0;
      known = 1;
    end else begin
      if (r && sz > 0) begin
        exp_q.push_back(q_m.pop_front());
        rtot++;
      end
      if (w && sz < 16) begin
        q_m.push_back(d);
        wtot++;
      end
      if (w && sz == 16) ovf_m = 1;
      if (r && sz == 0) unf_m = 1;
    end
  endtask
  always @(negedge clk) begin
    if (e_valid) begin
      chk("count", int'(count), e_count);
      chk("full", int'(full), int'(e_full));
      chk("wfull", int'(wfull), int'(e_full));
      chk("empty", int'(empty), int'(e_empty));
      chk("almost_full", int'(almost_full), int'(e_af));
      chk("almost_empty", int'(almost_empty), int'(e_ae));
      chk("waddr", int'(waddr), e_waddr);
      chk("raddr", int'(raddr), e_raddr);
      chk("wclken", int'(wclken), int'(e_wclken));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", int'(overflow), int'(e_ovf));
      chk("underflow", int'(underflow), int'(e_unf));
`endif
    end
    if (known && !rst && rd_en && !empty) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("rdata", int'(mem[raddr]), int'(exp_q.pop_front()));
    end
  end
  initial begin
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'h10);
    step(0, 0, 0, 8'h00);
    step(1, 1, 0, 8'h55);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'hA0);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 8'(8'h40 + i));
      step(0, 1, 0, 8'h00);
    end
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 8'($urandom));
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h70 + i));
    step(1, 0, 1, 8'h73);
    step(1, 0, 0, 8'h77);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    e_valid = 0;
    wr_en = 0;
    rd_en = 0;
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
